// File: rtl/sha256_msg_packer.sv
// sha256_msg_packer: packs a big-endian message byte stream into 512-bit
// SHA-256 blocks and applies the standard padding (0x80, zero fill, 64-bit
// big-endian bit length). Block byte k sits at m_block[511-8k -: 8].
//
// Optional feature: define SHA256_PACKER_BLKCNT_EN to add a 32-bit blk_cnt
// output that counts blocks emitted for the message currently in progress.
module sha256_msg_packer #(
  parameter int LEN_WIDTH = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   s_data,
  input  logic         s_valid,
  input  logic         s_last,
  output logic         s_ready,
  output logic [511:0] m_block,
  output logic         m_valid,
  output logic         m_last,
  input  logic         m_ready
`ifdef SHA256_PACKER_BLKCNT_EN
  ,
  output logic [31:0]  blk_cnt
`endif
);

  // FILL: taking bytes; PAD: append 0x80 (+length if it fits);
  // LEN: length-only block; EMIT: block presented to the core.
  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    LEN  = 2'd2,
    EMIT = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [511:0]           buf_q, buf_d;
  logic [6:0]             cnt_q, cnt_d;      // 0..64, byte write index
  logic [LEN_WIDTH-1:0]   len_q, len_d;      // message length in bits
  logic                   final_q, final_d;  // block in EMIT is the last one
  logic                   pend_pad_q, pend_pad_d; // message ended exactly on a block edge
  logic                   pad_done_q, pad_done_d; // 0x80 already written
  logic                   m_valid_q, m_valid_d;
  logic [63:0]            len_bits;

  // Length field is always 64 bits on the wire.
  assign len_bits = 64'(len_q);

  // Insert one byte at block index idx; byte idx MSB is bit 8*(63-idx)+7.
  function automatic logic [511:0] put_byte(input logic [511:0] b,
                                            input logic [5:0]   idx,
                                            input logic [7:0]   v);
    logic [511:0] r;
    r = b;
    r[{~idx, 3'b111} -: 8] = v;
    return r;
  endfunction

  assign s_ready = (state_q == FILL);
  assign m_block = buf_q;
  assign m_valid = m_valid_q;
  assign m_last  = final_q;  // only ever set while in EMIT

  // Next-state and datapath update for the packer
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    final_d    = final_q;
    pend_pad_d = pend_pad_q;
    pad_done_d = pad_done_q;
    case (state_q)
      FILL: begin
        if (s_valid) begin
          buf_d = put_byte(buf_q, cnt_q[5:0], s_data);
          cnt_d = cnt_q + 7'd1;
          len_d = len_q + LEN_WIDTH'(8);
          if (cnt_q == 7'd63) begin
            // Block is full; padding (if any) starts in the next block.
            state_d    = EMIT;
            final_d    = 1'b0;
            pend_pad_d = s_last;
          end else if (s_last) begin
            state_d = PAD;
          end
        end
      end
      PAD: begin
        buf_d      = put_byte(buf_q, cnt_q[5:0], 8'h80);
        pad_done_d = 1'b1;
        state_d    = EMIT;
        if (cnt_q <= 7'd55) begin
          // Room left for the length field in this block.
          buf_d[63:0] = len_bits;
          final_d     = 1'b1;
        end else begin
          final_d = 1'b0;
        end
      end
      LEN: begin
        buf_d[63:0] = len_bits;
        final_d     = 1'b1;
        state_d     = EMIT;
      end
      EMIT: begin
        if (m_ready) begin
          // Clearing here gives the zero fill for free.
          buf_d = '0;
          cnt_d = '0;
          if (final_q) begin
            len_d      = '0;
            pad_done_d = 1'b0;
            pend_pad_d = 1'b0;
            final_d    = 1'b0;
            state_d    = FILL;
          end else if (pend_pad_q) begin
            pend_pad_d = 1'b0;
            state_d    = PAD;
          end else if (pad_done_q) begin
            state_d = LEN;
          end else begin
            state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
    m_valid_d = (state_d == EMIT);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FILL;
      buf_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      final_q    <= 1'b0;
      pend_pad_q <= 1'b0;
      pad_done_q <= 1'b0;
      m_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      final_q    <= final_d;
      pend_pad_q <= pend_pad_d;
      pad_done_q <= pad_done_d;
      m_valid_q  <= m_valid_d;
    end
  end

`ifdef SHA256_PACKER_BLKCNT_EN
  logic [31:0] blk_cnt_q, blk_cnt_d;

  assign blk_cnt = blk_cnt_q;

  // Per-message block counter, restarts when the final block leaves
  always_comb begin
    blk_cnt_d = blk_cnt_q;
    if (m_valid_q && m_ready) begin
      blk_cnt_d = final_q ? 32'd0 : blk_cnt_q + 32'd1;
    end
  end

  // Block counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) blk_cnt_q <= '0;
    else     blk_cnt_q <= blk_cnt_d;
  end
`endif

endmodule

// File: tb/tb_sha256_msg_packer.sv
// Self-checking bench for sha256_msg_packer: directed table, hand-written
// backpressure/reset sequences and randomized messages against a padding model.
module tb_sha256_msg_packer;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    int          len;
    int          pat;        // 0 zeros, 1 0xFF, 2 incrementing, 3 'a','b',...
    int          exp_blocks;
    logic [31:0] exp_w0;     // first block, word 0
    logic [63:0] exp_lenf;   // last block, bits [63:0]
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   s_data;
  logic         s_valid, s_last, s_ready;
  logic [511:0] m_block;
  logic         m_valid, m_last, m_ready;
`ifdef SHA256_PACKER_BLKCNT_EN
  logic [31:0]  blk_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  sha256_msg_packer #(.LEN_WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_block(m_block), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready)
`ifdef SHA256_PACKER_BLKCNT_EN
    , .blk_cnt(blk_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: pad the whole message as a byte list, then cut block k out.
  function automatic logic [511:0] model_block(input bq_t msg, input int k);
    bq_t          p;
    logic [63:0]  bl;
    logic [511:0] b;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(msg.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    b = '0;
    for (int j = 0; j < 64; j++) b[511-8*j -: 8] = p[64*k + j];
    return b;
  endfunction

  function automatic int model_nblk(input int n);
    return (n + 9 + 63) / 64;
  endfunction

  // Stream one message with random gaps/backpressure and score every block.
  task automatic run_msg(input string nm, input bq_t msg, input int vpct, input int rpct,
                         output int nrecv, output logic [31:0] w0, output logic [63:0] lenf);
    int           si, bi, nblk, budget, t_last, t_mv;
    bit           hold;
    logic [511:0] hold_blk;
    si = 0; bi = 0; budget = 0; t_last = -1; t_mv = -1; hold = 0; hold_blk = '0;
    nblk = model_nblk(msg.size());
    w0 = '0; lenf = '0;
    while (bi < nblk && budget < 3000) begin
      @(negedge clk);
      if (hold) begin
        chk({nm, " stall_valid"}, 512'(m_valid), 512'(1));
        chk({nm, " stall_block"}, m_block, hold_blk);
      end
      s_valid = (si < msg.size()) && ($urandom_range(99) < vpct);
      s_data  = (si < msg.size()) ? msg[si] : 8'($urandom);
      s_last  = (si == msg.size() - 1);
      m_ready = ($urandom_range(99) < rpct);
      #1;
      if (t_last >= 0 && t_mv < 0 && m_valid) t_mv = cyc;
      if (m_valid) chk({nm, " s_ready_in_emit"}, 512'(s_ready), 512'(0));
      if (s_valid && s_ready) begin
        if (si == msg.size() - 1) t_last = cyc;
        si++;
      end
      if (m_valid && m_ready) begin
        chk($sformatf("%s blk%0d", nm, bi), m_block, model_block(msg, bi));
        chk($sformatf("%s last%0d", nm, bi), 512'(m_last), 512'(bi == nblk - 1));
`ifdef SHA256_PACKER_BLKCNT_EN
        chk($sformatf("%s blkcnt%0d", nm, bi), 512'(blk_cnt), 512'(bi));
`endif
        if (bi == 0) w0 = m_block[511:480];
        lenf = m_block[63:0];
        bi++;
        hold = 0;
      end else begin
        hold = m_valid;
        hold_blk = m_block;
      end
      budget++;
    end
    @(posedge clk);
    #1;
    s_valid = 0; s_last = 0; m_ready = 0;
    nrecv = bi;
    chk({nm, " timeout"}, 512'(budget < 3000), 512'(1));
    chk({nm, " latency"}, 512'(t_mv - t_last), 512'((msg.size() % 64 == 0) ? 1 : 2));
  endtask

  // Feed n non-final bytes back to back with the output side stalled.
  task automatic push_bytes(input int n);
    int acc, g;
    acc = 0; g = 0;
    while (acc < n && g < 500) begin
      @(negedge clk);
      s_valid = 1; s_data = 8'($urandom); s_last = 0; m_ready = 0;
      #1;
      if (s_ready) acc++;
      g++;
    end
    @(posedge clk);
    #1;
    s_valid = 0;
    chk("push_timeout", 512'(acc), 512'(n));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    #1;
    chk("rst_m_valid", 512'(m_valid), 512'(0));
    chk("rst_m_last",  512'(m_last),  512'(0));
    chk("rst_s_ready", 512'(s_ready), 512'(1));
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    vec_t        vecs[8];
    bq_t         msg, abc, one_a;
    int          nrecv, g;
    logic [31:0] w0;
    logic [63:0] lenf;

    vecs[0] = '{3,   3, 1, 32'h61626380, 64'h18};
    vecs[1] = '{55,  0, 1, 32'h00000000, 64'h1B8};
    vecs[2] = '{56,  1, 2, 32'hFFFFFFFF, 64'h1C0};
    vecs[3] = '{64,  2, 2, 32'h00010203, 64'h200};
    vecs[4] = '{1,   2, 1, 32'h00800000, 64'h8};
    vecs[5] = '{63,  1, 2, 32'hFFFFFFFF, 64'h1F8};
    vecs[6] = '{119, 0, 2, 32'h00000000, 64'h3B8};
    vecs[7] = '{120, 2, 3, 32'h00010203, 64'h3C0};

    rst = 1; s_data = 0; s_valid = 0; s_last = 0; m_ready = 0;
    #12;
    chk("reset_m_valid", 512'(m_valid), 512'(0));
    chk("reset_m_last",  512'(m_last),  512'(0));
    chk("reset_s_ready", 512'(s_ready), 512'(1));
    chk("reset_m_block", m_block, 512'(0));
`ifdef SHA256_PACKER_BLKCNT_EN
    chk("reset_blk_cnt", 512'(blk_cnt), 512'(0));
`endif
    @(negedge clk);
    rst = 0;

    // Directed table, no gaps and no backpressure.
    for (int v = 0; v < 8; v++) begin
      msg = {};
      for (int i = 0; i < vecs[v].len; i++) begin
        case (vecs[v].pat)
          0:       msg.push_back(8'h00);
          1:       msg.push_back(8'hFF);
          2:       msg.push_back(8'(i));
          default: msg.push_back(8'(8'h61 + i));
        endcase
      end
      run_msg($sformatf("vec%0d", v), msg, 100, 100, nrecv, w0, lenf);
      chk($sformatf("vec%0d nblk", v), 512'(nrecv), 512'(vecs[v].exp_blocks));
      chk($sformatf("vec%0d w0", v),   512'(w0),    512'(vecs[v].exp_w0));
      chk($sformatf("vec%0d lenf", v), 512'(lenf),  512'(vecs[v].exp_lenf));
    end

    // Backpressure: hold "abc" block for 10 cycles while next byte waits.
    abc = {8'h61, 8'h62, 8'h63};
    one_a = {8'h61};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s_valid = 1; s_data = abc[i]; s_last = (i == 2); m_ready = 0;
    end
    @(negedge clk);
    s_valid = 1; s_data = 8'h61; s_last = 1; m_ready = 0;
    g = 0;
    while (!m_valid && g < 10) begin
      @(negedge clk);
      g++;
    end
    chk("bp_wait", 512'(m_valid), 512'(1));
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid",   512'(m_valid), 512'(1));
      chk("bp_block",   m_block, model_block(abc, 0));
      chk("bp_s_ready", 512'(s_ready), 512'(0));
      @(negedge clk);
    end
    m_ready = 1;
    chk("bp_valid_xfer", 512'(m_valid), 512'(1));
    @(posedge clk);
    @(negedge clk);
    m_ready = 0;
    chk("bp_s_ready_after", 512'(s_ready), 512'(1));
    chk("bp_m_valid_after", 512'(m_valid), 512'(0));
    @(posedge clk);
    #1;
    s_valid = 0; s_last = 0; m_ready = 1;
    g = 0;
    while (!m_valid && g < 10) begin
      @(negedge clk);
      g++;
    end
    chk("bp_next_block", m_block, model_block(one_a, 0));
    chk("bp_next_last",  512'(m_last), 512'(1));
    @(posedge clk);
    #1;
    m_ready = 0;

    // Reset mid-message, then "abc" must come out clean.
    push_bytes(20);
    do_reset();
    run_msg("post_rst_abc", abc, 100, 100, nrecv, w0, lenf);
    chk("post_rst_w0",   512'(w0),   512'(32'h61626380));
    chk("post_rst_lenf", 512'(lenf), 512'(64'h18));

    // Reset mid-EMIT drops the pending block.
    push_bytes(64);
    chk("emit_before_rst", 512'(m_valid), 512'(1));
    do_reset();
    run_msg("post_rst2_abc", abc, 100, 100, nrecv, w0, lenf);

    // Randomized messages with random gaps and backpressure.
    for (int r = 0; r < 25; r++) begin
      int n;
      n = $urandom_range(1, 200);
      msg = {};
      for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
      run_msg($sformatf("rnd%0d", r), msg, $urandom_range(40, 100), $urandom_range(30, 100),
              nrecv, w0, lenf);
      chk($sformatf("rnd%0d nblk", r), 512'(nrecv), 512'(model_nblk(n)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
